// File: rtl/gcd_operand_feeder.sv
// Buffers operand pairs in a small circular FIFO and serialises each pair onto
// the GCD core bus (start, A, B), then waits for done with an abort timeout.
module gcd_operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         data_out,
  output logic                     start,
  input  logic                     done,
  output logic                     busy,
  output logic                     zero_err,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT} state_t;

  pair_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    tmo_cnt;
  logic [WIDTH-1:0] op_a, op_b;
  state_t           state;

  logic full, empty, push_hs, zero_op, push, pop;

  assign full     = (fifo_count == FULL_CNT);
  assign empty    = (fifo_count == '0);
  // Held low while rst is asserted so nothing is accepted in the reset cycle.
  assign in_ready = !rst && !full;
  assign push_hs  = in_valid && in_ready;
  assign zero_op  = (in_a == '0) || (in_b == '0);
  assign push     = push_hs && !zero_op;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      zero_err   <= 1'b0;
    end else begin
      zero_err <= push_hs && zero_op;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Bus outputs are registered: each is set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      tmo_cnt     <= '0;
      start       <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
    end else begin
      start       <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          op_a  <= mem[rd_ptr].a;
          op_b  <= mem[rd_ptr].b;
          start <= 1'b1;
          state <= START;
        end
        START: begin
          data_out <= op_a;
          state    <= SEND_A;
        end
        SEND_A: begin
          data_out <= op_b;
          state    <= SEND_B;
        end
        SEND_B: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a subtractive GCD core model
// that captures the serial bus and drives done.
module tb_gcd_operand_feeder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] data_out;
  logic         start, done, busy, zero_err, timeout_err;
  logic [2:0]   fifo_count;

  int n_cmp = 0, n_err = 0;
  int start_cnt = 0, tmo_seen = 0;
  int sc0, tc0;

  gcd_operand_feeder #(.WIDTH(W), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .data_out(data_out), .start(start),
    .done(done), .busy(busy), .zero_err(zero_err),
    .timeout_err(timeout_err), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  // Core model: start -> latch A -> latch B -> subtract until equal.
  typedef enum logic [1:0] {C_IDLE, C_GETA, C_GETB, C_RUN} cst_t;
  cst_t         cst = C_IDLE;
  logic [W-1:0] ca = '0, cb = '0;
  logic         core_hold = 1'b0;
  logic [W-1:0] results [$];

  assign done = (cst == C_RUN) && !core_hold && (ca == cb);

  always @(posedge clk) begin
    if (rst || timeout_err) cst <= C_IDLE;
    else case (cst)
      C_IDLE: if (start) cst <= C_GETA;
      C_GETA: begin ca <= data_out; cst <= C_GETB; end
      C_GETB: begin cb <= data_out; cst <= C_RUN; end
      C_RUN: if (!core_hold) begin
        if (ca == cb) begin results.push_back(ca); cst <= C_IDLE; end
        else if (ca > cb) ca <= ca - cb;
        else cb <= cb - ca;
      end
      default: cst <= C_IDLE;
    endcase
  end

  always @(posedge clk) begin
    if (start) start_cnt <= start_cnt + 1;
    if (timeout_err) tmo_seen <= tmo_seen + 1;
  end

  logic [W-1:0] a36 [5] = '{16'd12, 16'd9, 16'd10, 16'd7, 16'd15};
  logic [W-1:0] b36 [5] = '{16'd8, 16'd6, 16'd4, 16'd7, 16'd5};
  logic [W-1:0] g36 [5] = '{16'd4, 16'd3, 16'd2, 16'd7, 16'd5};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (w < 300 && !(busy === 1'b0 && fifo_count === 3'd0)) begin
      tick;
      w++;
    end
    chk(tag, 32'({busy, fifo_count}), 0);
  endtask

  initial begin
    // Reset state
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_zerr", 32'(zero_err), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 1);

    // Single pair 143/78: start, 0,143,78,0 on the bus, gcd 13
    push(16'd143, 16'd78);
    chk("p1_count", 32'(fifo_count), 1);
    chk("p1_start_early", 32'(start), 0);
    tick;
    chk("p1_start", 32'(start), 1);
    chk("p1_bus_start", 32'(data_out), 0);
    chk("p1_busy", 32'(busy), 1);
    chk("p1_popped", 32'(fifo_count), 0);
    tick;
    chk("p1_start_one", 32'(start), 0);
    chk("p1_bus_a", 32'(data_out), 143);
    tick;
    chk("p1_bus_b", 32'(data_out), 78);
    tick;
    chk("p1_bus_wait", 32'(data_out), 0);
    chk("p1_busy_wait", 32'(busy), 1);
    wait_drain("p1_drain");
    chk("p1_nres", 32'(results.size()), 1);
    if (results.size() > 0) chk("p1_gcd", 32'(results[0]), 13);
    chk("p1_no_tmo", 32'(tmo_seen), 0);

    // Zero operands rejected
    sc0 = start_cnt;
    push(16'd0, 16'd25);
    chk("z1_err", 32'(zero_err), 1);
    chk("z1_count", 32'(fifo_count), 0);
    tick;
    chk("z1_err_drop", 32'(zero_err), 0);
    chk("z1_busy", 32'(busy), 0);
    push(16'd25, 16'd0);
    chk("z2_err", 32'(zero_err), 1);
    chk("z2_count", 32'(fifo_count), 0);
    tick;
    chk("z2_err_drop", 32'(zero_err), 0);
    chk("z_no_start", 32'(start_cnt - sc0), 0);

    // Five pairs back-to-back with the core stalled
    results.delete();
    core_hold = 1'b1;
    sc0 = start_cnt;
    tc0 = tmo_seen;
    for (int i = 0; i < 5; i++) begin
      in_a = a36[i]; in_b = b36[i]; in_valid = 1'b1;
      chk("fill_ready", 32'(in_ready), 1);
      tick;
    end
    chk("fill_count", 32'(fifo_count), 4);
    chk("fill_full", 32'(in_ready), 0);
    in_a = 16'd99; in_b = 16'd33;
    tick;
    in_valid = 1'b0;
    chk("full_reject", 32'(fifo_count), 4);
    core_hold = 1'b0;
    wait_drain("fill_drain");
    chk("fill_nres", 32'(results.size()), 5);
    for (int i = 0; i < 5 && i < results.size(); i++)
      chk("fill_order", 32'(results[i]), 32'(g36[i]));
    chk("fill_starts", 32'(start_cnt - sc0), 5);
    chk("fill_no_tmo", 32'(tmo_seen - tc0), 0);

    // Timeout with done held low, TIMEOUT=8
    core_hold = 1'b1;
    tc0 = tmo_seen;
    push(16'd21, 16'd14);
    tick;
    chk("t_start", 32'(start), 1);
    tick;
    chk("t_bus_a", 32'(data_out), 21);
    tick;
    chk("t_bus_b", 32'(data_out), 14);
    for (int j = 0; j < 8; j++) begin
      tick;
      chk("t_wait_noerr", 32'(timeout_err), 0);
      chk("t_wait_busy", 32'(busy), 1);
    end
    tick;
    chk("t_err", 32'(timeout_err), 1);
    chk("t_idle", 32'(busy), 0);
    tick;
    chk("t_err_drop", 32'(timeout_err), 0);
    chk("t_one_pulse", 32'(tmo_seen - tc0), 1);
    core_hold = 1'b0;
    results.delete();
    push(16'd21, 16'd14);
    wait_drain("t_next_drain");
    chk("t_next_nres", 32'(results.size()), 1);
    if (results.size() > 0) chk("t_next_gcd", 32'(results[0]), 7);
    chk("t_next_no_tmo", 32'(tmo_seen - tc0), 1);

    // Push and pop together at count 2, pointers over three laps
    results.delete();
    for (int i = 0; i < 3; i++) push(16'(3 * (i + 1)), 16'(2 * (i + 1)));
    chk("lap_start_count", 32'(fifo_count), 2);
    for (int i = 3; i < 15; i++) begin
      for (int w = 0; w < 40 && busy !== 1'b0; w++) tick;
      chk("lap_idle", 32'(busy), 0);
      chk("lap_pre_count", 32'(fifo_count), 2);
      push(16'(3 * (i + 1)), 16'(2 * (i + 1)));
      chk("lap_count", 32'(fifo_count), 2);
      chk("lap_popped", 32'(busy), 1);
    end
    wait_drain("lap_drain");
    chk("lap_nres", 32'(results.size()), 15);
    for (int i = 0; i < 15 && i < results.size(); i++)
      chk("lap_order", 32'(results[i]), 32'(i + 1));

    // Reset during SEND_A with two pairs buffered
    results.delete();
    sc0 = start_cnt;
    tc0 = tmo_seen;
    push(16'd40, 16'd30);
    push(16'd50, 16'd20);
    push(16'd60, 16'd45);
    chk("mr_bus_a", 32'(data_out), 40);
    chk("mr_count", 32'(fifo_count), 2);
    rst = 1'b1;
    tick;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_count0", 32'(fifo_count), 0);
    chk("mr_data", 32'(data_out), 0);
    chk("mr_start", 32'(start), 0);
    chk("mr_ready", 32'(in_ready), 0);
    chk("mr_errs", 32'({zero_err, timeout_err}), 0);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick;
      chk("mr_quiet", 32'({start, busy, fifo_count}), 0);
    end
    chk("mr_one_start", 32'(start_cnt - sc0), 1);
    chk("mr_no_tmo", 32'(tmo_seen - tc0), 0);
    chk("mr_no_result", 32'(results.size()), 0);

    // Full-scale operands after reset
    push(16'hFFFF, 16'hFFFF);
    tick;
    tick;
    chk("max_bus_a", 32'(data_out), 32'h0000FFFF);
    wait_drain("max_drain");
    chk("max_nres", 32'(results.size()), 1);
    if (results.size() > 0) chk("max_gcd", 32'(results[0]), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
